// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan sequencer for a 4-digit seven-segment display.
// Walks the digit select with a blanked anti-ghosting gap and frame-latched data.
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int GAP_CYCLES  = 1000,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] value,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp_in,
    output logic        sel_a,
    output logic        sel_b,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        digit_blank,
    output logic        scan_tick
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'b00,
        ST_SHOW = 2'b01,
        ST_GAP  = 2'b10
    } state_t;

    localparam int REFRESH_LAST_I = REFRESH_DIV - 1;
    localparam int GAP_LAST_I     = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;
    localparam logic [CNT_W-1:0] REFRESH_LAST = REFRESH_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] GAP_LAST     = GAP_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r, nxt_state_s;
    logic [CNT_W-1:0]  cnt_r, nxt_cnt_s;
    logic [1:0]        sel_r, nxt_sel_s;
    logic [15:0]       frame_value_r, nxt_frame_value_s;
    logic [3:0]        frame_blank_r, nxt_frame_blank_s;
    logic [3:0]        frame_dp_r, nxt_frame_dp_s;
    logic [3:0]        digit_r, nxt_digit_s;
    logic              dp_r, nxt_dp_s;
    logic              digit_blank_r, nxt_digit_blank_s;
    logic              scan_tick_r, nxt_scan_tick_s;
    logic              load_frame_s;
    logic              show_digit_s;

    function automatic logic [3:0] pick_nibble(input logic [15:0] v, input logic [1:0] s);
        logic [3:0] n;
        case (s)
            2'b00:   n = v[3:0];
            2'b01:   n = v[7:4];
            2'b10:   n = v[11:8];
            2'b11:   n = v[15:12];
            default: n = v[3:0];
        endcase
        return n;
    endfunction

    // Next-state, prescaler, select and display-output computation.
    always_comb begin
        nxt_state_s       = state_r;
        nxt_cnt_s         = cnt_r;
        nxt_sel_s         = sel_r;
        nxt_digit_blank_s = digit_blank_r;
        nxt_scan_tick_s   = 1'b0;
        load_frame_s      = 1'b0;
        show_digit_s      = 1'b0;

        if (!en) begin
            nxt_state_s       = ST_OFF;
            nxt_cnt_s         = CNT_ZERO;
            nxt_sel_s         = 2'b00;
            nxt_digit_blank_s = 1'b1;
        end else begin
            case (state_r)
                ST_OFF: begin
                    nxt_state_s  = ST_SHOW;
                    nxt_cnt_s    = CNT_ZERO;
                    nxt_sel_s    = 2'b00;
                    load_frame_s = 1'b1;
                    show_digit_s = 1'b1;
                end
                ST_SHOW: begin
                    if (cnt_r == REFRESH_LAST) begin
                        nxt_cnt_s = CNT_ZERO;
                        if (GAP_CYCLES == 0) begin
                            nxt_sel_s       = sel_r + 2'b01;
                            load_frame_s    = (sel_r == 2'b11);
                            nxt_scan_tick_s = (sel_r == 2'b11);
                            show_digit_s    = 1'b1;
                        end else begin
                            nxt_state_s       = ST_GAP;
                            nxt_digit_blank_s = 1'b1;
                        end
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        nxt_state_s     = ST_SHOW;
                        nxt_cnt_s       = CNT_ZERO;
                        nxt_sel_s       = sel_r + 2'b01;
                        load_frame_s    = (sel_r == 2'b11);
                        nxt_scan_tick_s = (sel_r == 2'b11);
                        show_digit_s    = 1'b1;
                    end else begin
                        nxt_cnt_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    nxt_state_s       = ST_OFF;
                    nxt_cnt_s         = CNT_ZERO;
                    nxt_sel_s         = 2'b00;
                    nxt_digit_blank_s = 1'b1;
                end
            endcase
        end

        // Frame registers only change at a frame boundary, so mid-frame input edits never tear.
        if (load_frame_s) begin
            nxt_frame_value_s = value;
            nxt_frame_blank_s = blank;
            nxt_frame_dp_s    = dp_in;
        end else begin
            nxt_frame_value_s = frame_value_r;
            nxt_frame_blank_s = frame_blank_r;
            nxt_frame_dp_s    = frame_dp_r;
        end

        if (show_digit_s) begin
            nxt_digit_s       = pick_nibble(nxt_frame_value_s, nxt_sel_s);
            nxt_dp_s          = nxt_frame_dp_s[nxt_sel_s];
            nxt_digit_blank_s = nxt_frame_blank_s[nxt_sel_s];
        end else begin
            nxt_digit_s = digit_r;
            nxt_dp_s    = dp_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_OFF;
            cnt_r         <= CNT_ZERO;
            sel_r         <= 2'b00;
            frame_value_r <= 16'h0000;
            frame_blank_r <= 4'b0000;
            frame_dp_r    <= 4'b0000;
            digit_r       <= 4'h0;
            dp_r          <= 1'b0;
            digit_blank_r <= 1'b1;
            scan_tick_r   <= 1'b0;
        end else begin
            state_r       <= nxt_state_s;
            cnt_r         <= nxt_cnt_s;
            sel_r         <= nxt_sel_s;
            frame_value_r <= nxt_frame_value_s;
            frame_blank_r <= nxt_frame_blank_s;
            frame_dp_r    <= nxt_frame_dp_s;
            digit_r       <= nxt_digit_s;
            dp_r          <= nxt_dp_s;
            digit_blank_r <= nxt_digit_blank_s;
            scan_tick_r   <= nxt_scan_tick_s;
        end
    end

    assign sel_a       = sel_r[1];
    assign sel_b       = sel_r[0];
    assign digit       = digit_r;
    assign dp          = dp_r;
    assign digit_blank = digit_blank_r;
    assign scan_tick   = scan_tick_r;

endmodule
